ring_token_arbiter: RTL and testbench

Shares one core's ring transmit slot among N local requesters (data cache, messenger, lock unit, …) in the token-ring interconnect. It captures the circulating Token slot and grants it to one waiting requester per capture, round-robin. It muxes the owner's ring output, reinjects the Token when the owner finishes, and forwards all other traffic unchanged. On the master core it also injects the initial Token after reset.

---
 rtl/ring_pkg.sv | 24 ++
 rtl/ring_token_arbiter_if.sv | 36 +++
 rtl/ring_token_arbiter_rr_pick.sv | 33 +++
 rtl/ring_token_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_ring_token_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// Shared ring definitions: slot types, arbiter states, field widths.
package ring_pkg;

    localparam int DATA_W = 32;
    localparam int SRC_W  = 4;
    localparam int TYPE_W = 4;

    localparam logic [TYPE_W-1:0] SLOT_TOKEN   = 4'd1;
    localparam logic [TYPE_W-1:0] SLOT_ADDR    = 4'd2;
    localparam logic [TYPE_W-1:0] SLOT_WDATA   = 4'd3;
    localparam logic [TYPE_W-1:0] SLOT_AREQ    = 4'd5;
    localparam logic [TYPE_W-1:0] SLOT_GEXCL   = 4'd6;
    localparam logic [TYPE_W-1:0] SLOT_NULL    = 4'd7;

    localparam logic [SRC_W-1:0]  MASTER_CORE  = 4'd1;

    typedef enum logic [1:0] {
        ST_INJECT  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ring_token_arbiter_if.sv
// Ring slot and requester bundle around the token arbiter.
interface ring_token_arbiter_if #(
    parameter int N_REQ = 3
);
    import ring_pkg::*;

    logic [SRC_W-1:0]        whichCore;
    logic [DATA_W-1:0]       RingIn;
    logic [TYPE_W-1:0]       SlotTypeIn;
    logic [SRC_W-1:0]        SourceIn;
    logic [N_REQ-1:0]        want;
    logic [N_REQ-1:0]        drive;
    logic [DATA_W*N_REQ-1:0] reqRingOut;
    logic [TYPE_W*N_REQ-1:0] reqSlotTypeOut;
    logic [N_REQ-1:0]        acquire;
    logic [DATA_W-1:0]       RingOut;
    logic [TYPE_W-1:0]       SlotTypeOut;
    logic [SRC_W-1:0]        SourceOut;
    logic                    holding;
    logic                    holdError;

    modport master (
        output whichCore, RingIn, SlotTypeIn, SourceIn,
        output want, drive, reqRingOut, reqSlotTypeOut,
        input  acquire, RingOut, SlotTypeOut, SourceOut,
        input  holding, holdError
    );

    modport slave (
        input  whichCore, RingIn, SlotTypeIn, SourceIn,
        input  want, drive, reqRingOut, reqSlotTypeOut,
        output acquire, RingOut, SlotTypeOut, SourceOut,
        output holding, holdError
    );

endinterface

// File: rtl/ring_token_arbiter_rr_pick.sv
// Combinational round-robin one-hot picker starting at ptr_i.
module rr_pick #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o
);

    logic         found;
    logic [W:0]   sum;
    logic [W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (W+1)'(k);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            idx = sum[W-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Token capture, round-robin grant and ring output mux for one core.
// RING_ARB_WATCHDOG_EN adds a hold counter that forces release at MAX_HOLD.
module ring_token_arbiter
    import ring_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int MAX_HOLD = 64
) (
    input logic                  clock,
    input logic                  reset,
    ring_token_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || MAX_HOLD < 2) begin : g_bad_param
        $error("ring_token_arbiter: unsupported parameters");
    end

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] drv_first;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] drv_idx;
    logic [PTR_W-1:0] rr_next;

    logic             is_master;
    logic             tok_in;
    logic             any_want;
    logic             any_drive;
    logic             multi_drive;
    logic             own_drive;
    logic             own_sel;
    logic             capture;
    logic             tok_emit;
    logic             kill;
    logic             wd_fire;

    logic [DATA_W-1:0] req_data [N_REQ];
    logic [TYPE_W-1:0] req_type [N_REQ];

    assign is_master   = (bus.whichCore == MASTER_CORE);
    assign tok_in      = (bus.SlotTypeIn == SLOT_TOKEN);
    assign any_want    = |bus.want;
    assign any_drive   = |bus.drive;
    assign multi_drive = |(bus.drive & (bus.drive - N_REQ'(1)));
    assign own_drive   = bus.drive[owner_q];
    assign own_sel     = (state_q == ST_HOLD) && own_drive;
    assign capture     = (state_q == ST_IDLE) && tok_in && any_want;
    assign tok_emit    = (state_q == ST_RELEASE) ||
                         ((state_q == ST_INJECT) && is_master);
    assign bus.holding = (state_q == ST_HOLD) ||
                         (state_q == ST_RELEASE);
    assign bus.holdError = err_q;

    // A Token we capture, or a duplicate seen while holding, leaves as Null.
    assign kill = tok_in && (capture || bus.holding);

    rr_pick #(.N(N_REQ)) u_grant_pick (
        .req_i (bus.want),
        .ptr_i (rr_ptr_q),
        .gnt_o (grant)
    );

    rr_pick #(.N(N_REQ)) u_drive_pick (
        .req_i (bus.drive),
        .ptr_i ('0),
        .gnt_o (drv_first)
    );

    always_comb begin
        grant_idx = '0;
        drv_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_data[i] = bus.reqRingOut[i*DATA_W +: DATA_W];
            req_type[i] = bus.reqSlotTypeOut[i*TYPE_W +: TYPE_W];
            if (grant[i]) grant_idx = PTR_W'(i);
            if (drv_first[i]) drv_idx = PTR_W'(i);
        end
    end

    assign rr_next = (grant_idx == PTR_W'(N_REQ - 1)) ?
                     '0 : grant_idx + PTR_W'(1);

`ifdef RING_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    assign wd_fire = (state_q == ST_HOLD) &&
                     (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (capture) begin
            hold_cnt_d = '0;
        end else if (own_sel && hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        err_d       = err_q;
        bus.acquire = '0;
        unique case (state_q)
            ST_INJECT: begin
                // The initial Token is only lost if a resend took the slot.
                if (!is_master || !any_drive) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (capture) begin
                    bus.acquire = grant;
                    owner_d     = grant_idx;
                    rr_ptr_d    = rr_next;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!own_drive) begin
                    state_d = ST_RELEASE;
                end else if (wd_fire) begin
                    state_d = ST_RELEASE;
                    err_d   = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!any_drive) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INJECT;
            end
        endcase
        if (tok_in && bus.holding) begin
            err_d = 1'b1;
        end
        if (multi_drive) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        bus.RingOut     = bus.RingIn;
        bus.SlotTypeOut = bus.SlotTypeIn;
        bus.SourceOut   = bus.SourceIn;
        if (!reset) begin
            if (own_sel) begin
                bus.RingOut     = req_data[owner_q];
                bus.SlotTypeOut = req_type[owner_q];
                bus.SourceOut   = bus.whichCore;
            end else if (any_drive) begin
                bus.RingOut     = req_data[drv_idx];
                bus.SlotTypeOut = req_type[drv_idx];
                bus.SourceOut   = bus.whichCore;
            end else if (tok_emit) begin
                bus.RingOut     = '0;
                bus.SlotTypeOut = SLOT_TOKEN;
                bus.SourceOut   = bus.whichCore;
            end else if (kill) begin
                bus.SlotTypeOut = SLOT_NULL;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_INJECT;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Directed bench for ring_token_arbiter (N_REQ=3, MAX_HOLD=8).
module tb_ring_token_arbiter;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h8000_0002;
    localparam logic [31:0] RIN = 32'hDEAD_BEEF;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    ring_token_arbiter_if #(.N_REQ(3)) rif ();

    ring_token_arbiter #(
        .N_REQ    (3),
        .MAX_HOLD (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (rif)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_slot(input string tag,
                              input logic [31:0] d,
                              input logic [3:0] t,
                              input logic [3:0] s);
        check({tag, ".data"}, rif.RingOut, d);
        check({tag, ".type"}, 32'(rif.SlotTypeOut), 32'(t));
        check({tag, ".src"}, 32'(rif.SourceOut), 32'(s));
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        rif.RingIn     = RIN;
        rif.SlotTypeIn = 4'd7;
        rif.SourceIn   = 4'd5;
        rif.want       = 3'b000;
        rif.drive      = 3'b000;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clock = 1'b0;
        reset = 1'b1;
        rif.whichCore      = 4'd1;
        rif.reqRingOut     = {D2, D1, D0};
        rif.reqSlotTypeOut = {4'd2, 4'd5, 4'd3};
        idle_in();
        rif.SlotTypeIn = 4'd1;
        rif.want       = 3'b111;
        rif.drive      = 3'b001;
        #2;
        check("rst_acquire", 32'(rif.acquire), 32'd0);
        check_slot("rst_pass", RIN, 4'd1, 4'd5);
        check("rst_holding", 32'(rif.holding), 32'd0);
        check("rst_err", 32'(rif.holdError), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        idle_in();
        #1;
        check_slot("inject", 32'd0, 4'd1, 4'd1);
        check("inject_acq", 32'(rif.acquire), 32'd0);
        cyc();
        check_slot("idle_pass", RIN, 4'd7, 4'd5);

        // First token: rrPtr=0, want=101 -> requester 0
        rif.SlotTypeIn = 4'd1;
        rif.want       = 3'b101;
        rif.drive      = 3'b001;
        #1;
        check("rr_first", 32'(rif.acquire), 32'b001);
        check_slot("grant0_out", D0, 4'd3, 4'd1);
        cyc();
        idle_in();
        rif.drive = 3'b001;
        #1;
        check("hold0_holding", 32'(rif.holding), 32'd1);
        check_slot("hold0_out", D0, 4'd3, 4'd1);
        for (int i = 0; i < 6; i++) cyc();
        cyc();
        rif.drive = 3'b000;
        #1;
        check_slot("drop_no_token", RIN, 4'd7, 4'd5);
        check("drop_holding", 32'(rif.holding), 32'd1);
        cyc();
        check_slot("release_token", 32'd0, 4'd1, 4'd1);
        cyc();
        check("back_idle", 32'(rif.holding), 32'd0);

        // Second token: rrPtr=1, want=101 -> requester 2
        rif.SlotTypeIn = 4'd1;
        rif.want       = 3'b101;
        rif.drive      = 3'b100;
        #1;
        check("rr_second", 32'(rif.acquire), 32'b100);
        check_slot("grant2_out", D2, 4'd2, 4'd1);
        cyc();
        idle_in();
        rif.drive = 3'b100;
        cyc();
        rif.drive = 3'b000;
        #1;
        check_slot("drop2", RIN, 4'd7, 4'd5);
        cyc();
        rif.drive = 3'b100;
        #1;
        check_slot("resend_in_release", D2, 4'd2, 4'd1);
        cyc();
        rif.drive = 3'b000;
        #1;
        check_slot("token_after_resend", 32'd0, 4'd1, 4'd1);
        check("no_err_yet", 32'(rif.holdError), 32'd0);
        cyc();
        check("idle2", 32'(rif.holding), 32'd0);

        // Token with nobody wanting it passes through
        rif.SlotTypeIn = 4'd1;
        rif.SourceIn   = 4'd6;
        #1;
        check("nowant_acq", 32'(rif.acquire), 32'd0);
        check_slot("nowant_pass", RIN, 4'd1, 4'd6);
        cyc();

        // rrPtr=0, want=010 -> requester 1; duplicate Token in HOLD
        idle_in();
        rif.SlotTypeIn = 4'd1;
        rif.want       = 3'b010;
        rif.drive      = 3'b010;
        #1;
        check("rr_third", 32'(rif.acquire), 32'b010);
        cyc();
        idle_in();
        rif.SlotTypeIn = 4'd1;
        #1;
        check_slot("dup_killed", RIN, 4'd7, 4'd5);
        check("dup_acq", 32'(rif.acquire), 32'd0);
        cyc();
        idle_in();
        #1;
        check("dup_err", 32'(rif.holdError), 32'd1);
        check_slot("dup_release", 32'd0, 4'd1, 4'd1);
        cyc();
        check("err_sticky", 32'(rif.holdError), 32'd1);
        check("idle3", 32'(rif.holding), 32'd0);

        // rrPtr=2, want=001 -> requester 0; then reset mid-HOLD
        rif.SlotTypeIn = 4'd1;
        rif.want       = 3'b001;
        rif.drive      = 3'b001;
        #1;
        check("rr_wrap", 32'(rif.acquire), 32'b001);
        cyc();
        idle_in();
        rif.drive = 3'b001;
        #1;
        check("prerst_hold", 32'(rif.holding), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_holding", 32'(rif.holding), 32'd0);
        check("midrst_err", 32'(rif.holdError), 32'd0);
        check_slot("midrst_pass", RIN, 4'd7, 4'd5);
        cyc();
        reset = 1'b0;
        rif.drive = 3'b000;
        #1;
        check_slot("reinject", 32'd0, 4'd1, 4'd1);
        cyc();

        // rrPtr back to 0: want=011 -> requester 0; multi-drive in HOLD
        rif.SlotTypeIn = 4'd1;
        rif.want       = 3'b011;
        rif.drive      = 3'b001;
        #1;
        check("rr_after_rst", 32'(rif.acquire), 32'b001);
        cyc();
        idle_in();
        rif.drive = 3'b110;
        #1;
        check_slot("multi_lowest", D1, 4'd5, 4'd1);
        check("multi_err_pre", 32'(rif.holdError), 32'd0);
        cyc();
        rif.drive = 3'b000;
        #1;
        check("multi_err", 32'(rif.holdError), 32'd1);
        check_slot("multi_release", 32'd0, 4'd1, 4'd1);
        cyc();

        // Long hold: 20 owner drive cycles in HOLD
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        rif.SlotTypeIn = 4'd1;
        rif.want       = 3'b001;
        rif.drive      = 3'b001;
        #1;
        check("long_acq", 32'(rif.acquire), 32'b001);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            idle_in();
            rif.drive = 3'b001;
            #1;
`ifdef RING_ARB_WATCHDOG_EN
            check($sformatf("wd_err_%0d", i), 32'(rif.holdError),
                  (i >= 9) ? 32'd1 : 32'd0);
`else
            check($sformatf("long_err_%0d", i), 32'(rif.holdError), 32'd0);
`endif
            check($sformatf("long_out_%0d", i), rif.RingOut, D0);
        end
        cyc();
        rif.drive = 3'b000;
        #1;
`ifdef RING_ARB_WATCHDOG_EN
        check_slot("wd_token", 32'd0, 4'd1, 4'd1);
        cyc();
        check("wd_idle", 32'(rif.holding), 32'd0);
`else
        check_slot("long_drop", RIN, 4'd7, 4'd5);
        cyc();
        check_slot("long_token", 32'd0, 4'd1, 4'd1);
`endif
        cyc();

        // Non-master core: no injection, Token re-emitted with own id
        rif.whichCore = 4'd2;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check_slot("core2_noinject", RIN, 4'd7, 4'd5);
        cyc();
        rif.SlotTypeIn = 4'd1;
        rif.want       = 3'b100;
        rif.drive      = 3'b100;
        #1;
        check("core2_acq", 32'(rif.acquire), 32'b100);
        check_slot("core2_out", D2, 4'd2, 4'd2);
        cyc();
        idle_in();
        cyc();
        check_slot("core2_token", 32'd0, 4'd1, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
